// File: rtl/fp_widen_if.sv
// Handshake bundle for fp_widen_pipe.
// Operand side is i_valid/i_ready/a/i_tag; result side is o_valid/o_ready/o/o_tag/o_nv.
interface fp_widen_if #(
  parameter int SRC_WID = 32,
  parameter int DST_WID = 128,
  parameter int TAG_WID = 8
);
  logic               i_valid;
  logic               i_ready;
  logic [SRC_WID-1:0] a;
  logic [TAG_WID-1:0] i_tag;
  logic               o_valid;
  logic               o_ready;
  logic [DST_WID-1:0] o;
  logic [TAG_WID-1:0] o_tag;
  logic               o_nv;

  modport master (
    output i_valid, a, i_tag, o_ready,
    input  i_ready, o_valid, o, o_tag, o_nv
  );

  modport slave (
    input  i_valid, a, i_tag, o_ready,
    output i_ready, o_valid, o, o_tag, o_nv
  );
endinterface

// File: rtl/fp_widen_pipe.sv
// Three-stage exact IEEE-754 widening converter (decompose / normalise / pack).
// Build macro FCVT_DENORM_EN: defined normalises denormal inputs, undefined flushes them to signed zero.
module fp_widen_pipe #(
  parameter int SRC_WID = 32,
  parameter int DST_WID = 128,
  parameter int TAG_WID = 8
) (
  input  logic      clk,
  input  logic      rst,
  fp_widen_if.slave bus
);
  function automatic int exw_of(input int wid);
    case (wid)
      16:      return 5;
      32:      return 8;
      64:      return 11;
      default: return 15;
    endcase
  endfunction

  localparam int EXW_S  = exw_of(SRC_WID);
  localparam int EXW_D  = exw_of(DST_WID);
  localparam int FMW_S  = SRC_WID - EXW_S - 1;
  localparam int FMW_D  = DST_WID - EXW_D - 1;
  localparam int BIAS_S = (1 << (EXW_S - 1)) - 1;
  localparam int BIAS_D = (1 << (EXW_D - 1)) - 1;
  localparam int FSH    = FMW_D - FMW_S;
  localparam logic [EXW_D-1:0] BIAS_DIFF = EXW_D'(BIAS_D - BIAS_S);

  if ((SRC_WID != 16 && SRC_WID != 32 && SRC_WID != 64) ||
      (DST_WID != 32 && DST_WID != 64 && DST_WID != 128) ||
      (DST_WID <= SRC_WID)) begin : g_bad_cfg
    $error("fp_widen_pipe: illegal SRC_WID/DST_WID combination");
  end

  logic v1, v2, v3;
  logic acc1, acc2, acc3;

  // A stage takes new data when it is empty or its occupant moves on this edge.
  assign acc3 = !v3 || bus.o_ready;
  assign acc2 = !v2 || acc3;
  assign acc1 = !v1 || acc2;
  assign bus.i_ready = !rst && acc1;

  logic [EXW_S-1:0] a_exp;
  logic [FMW_S-1:0] a_frac;
  logic             a_exp_max, a_exp_nil, a_frac_nz;

  assign a_exp     = bus.a[SRC_WID-2 -: EXW_S];
  assign a_frac    = bus.a[FMW_S-1:0];
  assign a_exp_max = &a_exp;
  assign a_exp_nil = ~|a_exp;
  assign a_frac_nz = |a_frac;

  logic               s1_sign, s1_nan, s1_inf, s1_zero;
  logic [EXW_S-1:0]   s1_exp;
  logic [FMW_S-1:0]   s1_frac;
  logic [TAG_WID-1:0] s1_tag;

`ifdef FCVT_DENORM_EN
  localparam int LZW = $clog2(FMW_S);

  function automatic logic [LZW-1:0] lzc(input logic [FMW_S-1:0] f);
    lzc = '0;
    for (int i = 0; i < FMW_S; i++) begin
      if (f[i]) lzc = LZW'(FMW_S - 1 - i);
    end
  endfunction

  logic           s1_den;
  logic [LZW-1:0] s1_lz;
`endif

  logic               s2_sign, s2_nan, s2_inf, s2_zero, s2_nv;
  logic [EXW_D-1:0]   s2_exp;
  logic [FMW_D-1:0]   s2_frac;
  logic [TAG_WID-1:0] s2_tag;

  logic [EXW_D-1:0] xd;
  logic [FMW_S-1:0] fn;

  // Widening cannot overflow or underflow for legal width pairs, so no guard bit is carried.
  always_comb begin
    xd = EXW_D'(s1_exp) + BIAS_DIFF;
    fn = s1_frac;
`ifdef FCVT_DENORM_EN
    if (s1_den) begin
      xd = BIAS_DIFF - EXW_D'(s1_lz);
      fn = (s1_frac << s1_lz) << 1;
    end
`endif
  end

  logic [DST_WID-1:0] pk;

  always_comb begin
    pk = {s2_sign, s2_exp, s2_frac};
    if (s2_nan) begin
      pk = {s2_sign, {EXW_D{1'b1}}, 1'b1, s2_frac[FMW_D-2:0]};
    end else if (s2_inf) begin
      pk = {s2_sign, {EXW_D{1'b1}}, {FMW_D{1'b0}}};
    end else if (s2_zero) begin
      pk = {s2_sign, {(DST_WID-1){1'b0}}};
    end
  end

  logic [DST_WID-1:0] o_r;
  logic [TAG_WID-1:0] tag3;
  logic               nv3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      s1_sign <= 1'b0;
      s1_nan  <= 1'b0;
      s1_inf  <= 1'b0;
      s1_zero <= 1'b0;
      s1_exp  <= '0;
      s1_frac <= '0;
      s1_tag  <= '0;
`ifdef FCVT_DENORM_EN
      s1_den  <= 1'b0;
      s1_lz   <= '0;
`endif
      s2_sign <= 1'b0;
      s2_nan  <= 1'b0;
      s2_inf  <= 1'b0;
      s2_zero <= 1'b0;
      s2_nv   <= 1'b0;
      s2_exp  <= '0;
      s2_frac <= '0;
      s2_tag  <= '0;
      o_r     <= '0;
      tag3    <= '0;
      nv3     <= 1'b0;
    end else begin
      if (acc1) begin
        v1 <= bus.i_valid;
        if (bus.i_valid) begin
          s1_sign <= bus.a[SRC_WID-1];
          s1_exp  <= a_exp;
          s1_frac <= a_frac;
          s1_tag  <= bus.i_tag;
          s1_nan  <= a_exp_max && a_frac_nz;
          s1_inf  <= a_exp_max && !a_frac_nz;
`ifdef FCVT_DENORM_EN
          s1_zero <= a_exp_nil && !a_frac_nz;
          s1_den  <= a_exp_nil && a_frac_nz;
          s1_lz   <= lzc(a_frac);
`else
          s1_zero <= a_exp_nil;
`endif
        end
      end
      if (acc2) begin
        v2 <= v1;
        if (v1) begin
          s2_sign <= s1_sign;
          s2_exp  <= xd;
          s2_frac <= {fn, {FSH{1'b0}}};
          s2_nan  <= s1_nan;
          s2_inf  <= s1_inf;
          s2_zero <= s1_zero;
          s2_nv   <= s1_nan && !s1_frac[FMW_S-1];
          s2_tag  <= s1_tag;
        end
      end
      if (acc3) begin
        v3 <= v2;
        if (v2) begin
          o_r  <= pk;
          tag3 <= s2_tag;
          nv3  <= s2_nv;
        end
      end
    end
  end

  assign bus.o_valid = v3;
  assign bus.o       = o_r;
  assign bus.o_tag   = tag3;
  assign bus.o_nv    = nv3;
endmodule
